// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 constants, state encoding and round-constant lookup
package sha256_pkg;

  localparam int ROUNDS    = 64;
  localparam int MSG_WORDS = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MSG,
    ST_EXPAND,
    ST_UPDATE,
    ST_DONE
  } state_t;

  localparam logic [31:0] IV_TAB [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_TAB [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] sha256_iv(input logic [2:0] i);
    return IV_TAB[i];
  endfunction

  function automatic logic [31:0] sha256_k(input logic [5:0] idx);
    return K_TAB[idx];
  endfunction

endpackage

// File: rtl/sha256_round_cnt.sv
// rtl/sha256_round_cnt.sv - round index counter with clear, enable and terminal flags
module sha256_round_cnt #(
  parameter int ROUNDS    = 64,
  parameter int MSG_WORDS = 16,
  parameter int IDX_W     = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [IDX_W-1:0] idx,
  output logic             at_msg_end,
  output logic             at_last
);

  localparam logic [IDX_W-1:0] MSG_END  = IDX_W'(MSG_WORDS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  assign at_msg_end = (idx == MSG_END);
  assign at_last    = (idx == LAST_IDX);

  // Saturates at the last round so the index can never run past the K table.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      idx <= '0;
    end else if (en && !at_last) begin
      idx <= idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/sha256_round_ctrl.sv
// rtl/sha256_round_ctrl.sv - SHA-256 compression sequencer: block intake, round indexing, chaining, digest handshake
module sha256_round_ctrl #(
  parameter int ROUNDS    = 64,
  parameter int MSG_WORDS = 16,
  parameter int IDX_W     = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blk_valid,
  input  logic             blk_last,
  input  logic             word_valid,
  output logic             word_ready,
  output logic [IDX_W-1:0] round_idx,
  output logic             sched_sel,
  output logic             core_en,
  output logic             init_iv,
  output logic             load_state,
  output logic             h_update,
  output logic             busy,
  output logic             digest_valid,
  input  logic             digest_ack
);

  import sha256_pkg::*;

  state_t state;
  logic   chain_r;
  logic   last_r;
  logic   cnt_msg_end;
  logic   cnt_last;

  // init_iv must land in the cycle blk_valid is seen so H holds the IV before LOAD copies it.
  assign init_iv = rst && (state == ST_IDLE) && blk_valid && !chain_r;
  assign core_en = rst && (((state == ST_MSG) && word_valid) || (state == ST_EXPAND));

  sha256_round_cnt #(
    .ROUNDS    (ROUNDS),
    .MSG_WORDS (MSG_WORDS),
    .IDX_W     (IDX_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .en         (core_en),
    .clr        (state == ST_UPDATE),
    .idx        (round_idx),
    .at_msg_end (cnt_msg_end),
    .at_last    (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      chain_r      <= 1'b0;
      last_r       <= 1'b0;
      load_state   <= 1'b0;
      h_update     <= 1'b0;
      busy         <= 1'b0;
      word_ready   <= 1'b0;
      sched_sel    <= 1'b0;
      digest_valid <= 1'b0;
    end else begin
      load_state <= 1'b0;
      h_update   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (blk_valid) begin
            last_r     <= blk_last;
            state      <= ST_LOAD;
            load_state <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_LOAD: begin
          state      <= ST_MSG;
          word_ready <= 1'b1;
          sched_sel  <= 1'b1;
        end
        ST_MSG: begin
          if (word_valid && cnt_msg_end) begin
            state      <= ST_EXPAND;
            word_ready <= 1'b0;
            sched_sel  <= 1'b0;
          end
        end
        ST_EXPAND: begin
          if (cnt_last) begin
            state    <= ST_UPDATE;
            h_update <= 1'b1;
          end
        end
        ST_UPDATE: begin
          busy    <= 1'b0;
          chain_r <= !last_r;
          if (last_r) begin
            state        <= ST_DONE;
            digest_valid <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_DONE: begin
          if (digest_ack) begin
            state        <= ST_IDLE;
            digest_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb/tb_sha256_round_ctrl.sv - directed bench for sha256_round_ctrl with a behavioural SHA-256 datapath
module tb_sha256_round_ctrl;

  import sha256_pkg::*;

  logic       clk;
  logic       rst;
  logic       blk_valid, blk_last, word_valid, digest_ack;
  logic       word_ready, sched_sel, core_en, init_iv, load_state, h_update, busy, digest_valid;
  logic [6:0] round_idx;

  sha256_round_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .blk_valid    (blk_valid),
    .blk_last     (blk_last),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .round_idx    (round_idx),
    .sched_sel    (sched_sel),
    .core_en      (core_en),
    .init_iv      (init_iv),
    .load_state   (load_state),
    .h_update     (h_update),
    .busy         (busy),
    .digest_valid (digest_valid),
    .digest_ack   (digest_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_2BL = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  int n_vec = 0;
  int n_mis = 0;

  // Datapath driven by the controller strobes.
  logic [31:0] blk_w [3][16];
  int          cur_blk = 0;
  logic [31:0] hh [8];
  logic [31:0] work [8];
  logic [31:0] win [16];
  logic [31:0] wt, t1, t2;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x); return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22); endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x); return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25); endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x); return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3); endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x); return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10); endfunction

  always_comb begin
    wt = sched_sel ? blk_w[cur_blk][round_idx[3:0]] : (ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0]);
    t1 = work[7] + bsig1(work[4]) + ((work[4] & work[5]) ^ (~work[4] & work[6])) + sha256_k(round_idx[5:0]) + wt;
    t2 = bsig0(work[0]) + ((work[0] & work[1]) ^ (work[0] & work[2]) ^ (work[1] & work[2]));
  end

  always @(posedge clk) begin
    if (init_iv) for (int i = 0; i < 8; i++) hh[i] <= sha256_iv(3'(i));
    if (h_update) for (int i = 0; i < 8; i++) hh[i] <= hh[i] + work[i];
    if (load_state) for (int i = 0; i < 8; i++) work[i] <= hh[i];
    if (core_en) begin
      work[0] <= t1 + t2; work[1] <= work[0]; work[2] <= work[1]; work[3] <= work[2];
      work[4] <= work[3] + t1; work[5] <= work[4]; work[6] <= work[5]; work[7] <= work[6];
      for (int i = 0; i < 15; i++) win[i] <= win[i + 1];
      win[15] <= wt;
    end
  end

  function automatic logic [255:0] digest();
    return {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]};
  endfunction

  function automatic logic [7:0] flags();
    return {init_iv, load_state, h_update, busy, word_ready, sched_sel, core_en, digest_valid};
  endfunction

  typedef struct {
    int         run;
    int         cyc;
    logic [6:0] idx;
    logic [7:0] flg;
  } vec_t;
  vec_t tbl[$];

  logic [6:0] tr_idx [5][200];
  logic [7:0] tr_flg [5][200];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    blk_valid = 1'b0; word_valid = 1'b0; digest_ack = 1'b0;
  endtask

  // Cycle 0 is the IDLE cycle with blk_valid high; returns the h_update (or abort) cycle.
  task automatic drive_block(input int run, input int blk, input bit last, input bit stall,
                             input int abort_idx, output int upd_cyc);
    upd_cyc = -1;
    cur_blk = blk;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      blk_valid  = (c == 0);
      blk_last   = last;
      word_valid = stall ? ((c % 2) == 0) : 1'b1;
      digest_ack = 1'b0;
      #1;
      if (run >= 0) begin
        tr_idx[run][c] = round_idx;
        tr_flg[run][c] = flags();
      end
      if (abort_idx >= 0 && busy && !sched_sel && round_idx == 7'(abort_idx)) begin
        rst = 1'b0;
        upd_cyc = c;
        break;
      end
      if (h_update) begin
        upd_cyc = c;
        break;
      end
    end
  endtask

  task automatic take_digest(input string nm, input logic [255:0] exp);
    idle_cycle();
    #1;
    chk({nm, "_dv"}, digest_valid, 1'b1);
    chk({nm, "_digest"}, digest(), exp);
    @(negedge clk);
    digest_ack = 1'b1;
    idle_cycle();
  endtask

  initial begin
    int upd;
    int viol;

    for (int i = 0; i < 16; i++) begin
      blk_w[0][i] = 32'h0;
      blk_w[2][i] = 32'h0;
      blk_w[1][i] = (i < 14) ? {8'(97 + i), 8'(98 + i), 8'(99 + i), 8'(100 + i)} : 32'h0;
    end
    blk_w[0][0]  = 32'h61626380;
    blk_w[0][15] = 32'h00000018;
    blk_w[1][14] = 32'h80000000;
    blk_w[2][15] = 32'h000001c0;

    tbl.push_back('{0, 0,  7'd0,  8'b1000_0000});
    tbl.push_back('{0, 1,  7'd0,  8'b0101_0000});
    tbl.push_back('{0, 2,  7'd0,  8'b0001_1110});
    tbl.push_back('{0, 17, 7'd15, 8'b0001_1110});
    tbl.push_back('{0, 18, 7'd16, 8'b0001_0010});
    tbl.push_back('{0, 40, 7'd38, 8'b0001_0010});
    tbl.push_back('{0, 65, 7'd63, 8'b0001_0010});
    tbl.push_back('{0, 66, 7'd63, 8'b0011_0000});
    tbl.push_back('{3, 0,  7'd0,  8'b1000_0000});
    tbl.push_back('{1, 0,  7'd0,  8'b0000_0000});
    tbl.push_back('{1, 1,  7'd0,  8'b0101_0000});
    tbl.push_back('{2, 0,  7'd0,  8'b1000_0000});
    tbl.push_back('{2, 3,  7'd1,  8'b0001_1100});
    tbl.push_back('{2, 4,  7'd1,  8'b0001_1110});
    tbl.push_back('{2, 32, 7'd15, 8'b0001_1110});
    tbl.push_back('{2, 33, 7'd16, 8'b0001_0010});
    tbl.push_back('{2, 81, 7'd63, 8'b0011_0000});
    tbl.push_back('{4, 0,  7'd0,  8'b1000_0000});

    rst = 1'b0; blk_valid = 1'b0; blk_last = 1'b0; word_valid = 1'b0; digest_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {word_ready, round_idx, flags()}, '0);
    rst = 1'b1;
    idle_cycle();

    // Single block "abc", then digest held while blk_valid pulses.
    drive_block(0, 0, 1'b1, 1'b0, -1, upd);
    chk("abc_upd_cycle", upd, 66);
    viol = 0;
    for (int c = 2; c <= 65; c++) if (tr_idx[0][c] !== 7'(c - 2)) viol++;
    chk("abc_idx_contig", viol, 0);
    idle_cycle();
    #1;
    chk("abc_dv", digest_valid, 1'b1);
    chk("abc_digest", digest(), DIG_ABC);
    viol = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      blk_valid = (k % 2 == 0);
      #1;
      if (!digest_valid || init_iv || load_state || busy) viol++;
    end
    @(negedge clk);
    blk_valid = 1'b0; digest_ack = 1'b1;
    #1;
    if (!digest_valid || load_state) viol++;
    chk("done_hold", viol, 0);
    idle_cycle();
    #1;
    chk("ack_to_idle", {digest_valid, busy, load_state}, 3'b000);

    // Two-block message with chaining.
    drive_block(3, 1, 1'b0, 1'b0, -1, upd);
    chk("blk1_upd_cycle", upd, 66);
    drive_block(1, 2, 1'b1, 1'b0, -1, upd);
    chk("blk2_upd_cycle", upd, 66);
    take_digest("two_block", DIG_2BL);

    // "abc" with word_valid toggling through MSG.
    drive_block(2, 0, 1'b1, 1'b1, -1, upd);
    chk("stall_upd_cycle", upd, 81);
    viol = 0;
    for (int c = 2; c <= 32; c++) begin
      if (tr_flg[2][c][3]) begin
        if (tr_flg[2][c][1] !== 1'((c % 2) == 0)) viol++;
        if (tr_idx[2][c + 1] !== 7'(tr_idx[2][c] + 7'((c % 2) == 0))) viol++;
      end
    end
    chk("stall_core_en_idx", viol, 0);
    take_digest("stall", DIG_ABC);

    // Reset at round 30 while chained into block 2, then a fresh "abc".
    drive_block(-1, 1, 1'b0, 1'b0, -1, upd);
    drive_block(-1, 2, 1'b1, 1'b0, 30, upd);
    chk("abort_reached", upd >= 0, 1'b1);
    @(negedge clk);
    #1;
    chk("abort_reset_outputs", {word_ready, round_idx, flags()}, '0);
    rst = 1'b1;
    idle_cycle();
    drive_block(4, 0, 1'b1, 1'b0, -1, upd);
    chk("rerun_upd_cycle", upd, 66);
    take_digest("rerun", DIG_ABC);

    foreach (tbl[i]) begin
      chk($sformatf("tbl_run%0d_cyc%0d", tbl[i].run, tbl[i].cyc),
          {tr_idx[tbl[i].run][tbl[i].cyc], tr_flg[tbl[i].run][tbl[i].cyc]},
          {tbl[i].idx, tbl[i].flg});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
